// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-op encodings and the shift-amount width.
package alu_pkg;

  localparam int ALU_SH_W = 6;

  typedef enum logic [1:0] {
    ALU_SH_SRL = 2'd0,
    ALU_SH_SLL = 2'd1,
    ALU_SH_SRA = 2'd2,
    ALU_SH_RSV = 2'd3
  } alu_sh_op_e;

endpackage

// File: rtl/alu_srl.sv
// Combinational logical-right shifter; an amount of N clears the word.
module alu_srl #(
  parameter int N  = 32,
  parameter int SW = $clog2(N + 1)
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic [N-1:0]  z
);

  assign z = a >> s;

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage valid/ready shift unit; SLL and SRA are folded onto one
// logical-right shifter by bit reversal and inversion around it.
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_a,
  input  logic [ALU_SH_W-1:0] in_s,
  input  logic [1:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_z,
  output logic [1:0]          out_op
);

  localparam int SCW = $clog2(N + 1);

  logic                v1_reg;
  logic [N-1:0]        a1_reg;
  logic [ALU_SH_W-1:0] s1_reg;
  logic [1:0]          op1_reg;
  logic                v2_reg;
  logic [N-1:0]        z2_reg;
  logic [1:0]          op2_reg;

  logic                ready1;
  logic                ready2;
  logic [SCW-1:0]      sc;
  logic                is_sll;
  logic                is_neg_sra;
  logic [N-1:0]        a1_rev;
  logic [N-1:0]        srl_a;
  logic [N-1:0]        srl_z;
  logic [N-1:0]        srl_rev;
  logic [N-1:0]        z_next;

  assign ready2   = !v2_reg || out_ready;
  assign ready1   = !v1_reg || ready2;
  assign in_ready = ready1;

  assign out_valid = v2_reg;
  assign out_z     = z2_reg;
  assign out_op    = op2_reg;

  // Amounts at or beyond the width saturate to N, giving the full-width fill.
  always_comb begin
    if (int'(s1_reg) >= N) sc = SCW'(N);
    else                   sc = SCW'(s1_reg);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rev
      assign a1_rev[gi]  = a1_reg[N-1-gi];
      assign srl_rev[gi] = srl_z[N-1-gi];
    end
  endgenerate

  assign is_sll     = (op1_reg == ALU_SH_SLL);
  assign is_neg_sra = (op1_reg == ALU_SH_SRA) && a1_reg[N-1];

  // Negative SRA shifts in ones: invert, shift in zeros, invert back.
  always_comb begin
    srl_a  = a1_reg;
    z_next = srl_z;
    if (is_sll) begin
      srl_a  = a1_rev;
      z_next = srl_rev;
    end else if (is_neg_sra) begin
      srl_a  = ~a1_reg;
      z_next = ~srl_z;
    end
  end

  alu_srl #(.N(N), .SW(SCW)) u_srl (
    .a(srl_a),
    .s(sc),
    .z(srl_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      a1_reg  <= '0;
      s1_reg  <= '0;
      op1_reg <= '0;
      v2_reg  <= 1'b0;
      z2_reg  <= '0;
      op2_reg <= '0;
    end else begin
      if (ready2) begin
        v2_reg  <= v1_reg;
        z2_reg  <= z_next;
        op2_reg <= op1_reg;
      end
      if (ready1) begin
        v1_reg  <= in_valid;
        a1_reg  <= in_a;
        s1_reg  <= in_s;
        op1_reg <= in_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe: directed vectors, stall, reset and random traffic.
module tb_alu_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [5:0]  in_s;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [1:0]  out_op;

  alu_shift_pipe #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_s(in_s), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_op(out_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [1:0]  op;
    int          t;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [5:0]  s;
    logic [1:0]  op;
    logic [31:0] z;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   del_cnt = 0;
  bit   rand_on = 1'b0;
  bit   quiet = 1'b0;

  vec_t vecs[9] = '{
    '{32'h0000000F, 6'd28, 2'd1, 32'hF0000000},
    '{32'hF0000000, 6'd4,  2'd2, 32'hFF000000},
    '{32'h70000000, 6'd4,  2'd2, 32'h07000000},
    '{32'h80000001, 6'd0,  2'd0, 32'h80000001},
    '{32'h80000001, 6'd31, 2'd0, 32'h00000001},
    '{32'h80000001, 6'd32, 2'd0, 32'h00000000},
    '{32'h80000001, 6'd63, 2'd0, 32'h00000000},
    '{32'h80000001, 6'd40, 2'd2, 32'hFFFFFFFF},
    '{32'h80000001, 6'd32, 2'd1, 32'h00000000}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [5:0] s,
                                        input logic [1:0] op);
    case (op)
      2'd1:    return (s >= 6'd32) ? 32'd0 : (a << s);
      2'd2:    return (s >= 6'd32) ? {32{a[31]}} : 32'($signed(a) >>> s);
      default: return (s >= 6'd32) ? 32'd0 : (a >> s);
    endcase
  endfunction

  // Monitor: every handshake on the output side is matched against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", out_z);
      end else begin
        e = sb.pop_front();
        check("out_z", out_z, e.z);
        check("out_op", {30'd0, out_op}, {30'd0, e.op});
        if (e.lat) check("latency", 32'(cyc - e.t), 32'd2);
        del_cnt++;
        if (!quiet) $display("result %0d: z=%h op=%0d", del_cnt, out_z, out_op);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [5:0] s, input logic [1:0] op,
                      input logic [31:0] z, input bit lat);
    in_valid = 1'b1;
    in_a     = a;
    in_s     = s;
    in_op    = op;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{z, op, cyc, lat});
        acc_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 1000 cycles, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 300 && sb.size() != 0; w++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'hDEADBEEF;
    in_s      = 6'd3;
    in_op     = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_z", out_z, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    send(32'h80000000, 6'd4, 2'd0, 32'h08000000, 1'b1);
    drain();
    foreach (vecs[i]) send(vecs[i].a, vecs[i].s, vecs[i].op, vecs[i].z, 1'b0);
    drain();

    // Back-to-back stream with a three-cycle stall after the second result.
    base = del_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 6'd1, 2'd0, 32'(i) >> 1, 1'b0);
      end
      begin
        for (int w = 0; w < 200 && del_cnt < base + 2; w++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("stream_no_gap", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();
    check("stream_count", 32'(del_cnt - base), 32'd8);

    // Fill both stages, then reset between clock edges.
    out_ready = 1'b0;
    send(32'h00000011, 6'd0, 2'd0, 32'h00000011, 1'b0);
    send(32'h00000022, 6'd0, 2'd0, 32'h00000022, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_out_z", out_z, 32'd0);
    sb.delete();
    acc_cnt -= 2;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the reference model with random backpressure.
    quiet   = 1'b1;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin : rnd
          logic [31:0] a;
          logic [5:0]  s;
          logic [1:0]  op;
          a  = $urandom;
          s  = 6'($urandom_range(0, 63));
          op = 2'($urandom_range(0, 3));
          send(a, s, op, model(a, s, op), 1'b0);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          if (rand_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("accept_vs_deliver", 32'(acc_cnt), 32'(del_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
